// File: rtl/interleave_mon_pkg.sv
// Shared error codes and event-record layout for the interleaved chain monitor.
package interleave_mon_pkg;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SPUR    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVF     = 2'b11;

    // Record shape for the default 5-stage chain with a 16-bit stamp.
    localparam int unsigned EVT_MASK_W = 6;
    localparam int unsigned EVT_TIME_W = 16;

    typedef struct packed {
        logic [EVT_MASK_W-1:0] mask;
        logic [EVT_TIME_W-1:0] stamp;
    } evt_rec_t;

endpackage

// File: rtl/interleave_chain_monitor_event_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is read straight from storage.
module event_fifo #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata_c,
    output logic             valid_c,
    output logic             full_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign valid_c = (wr_ptr != rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && valid_c;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full_c || do_pop);
    assign rdata_c = valid_c ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/interleave_chain_monitor.sv
// Samples every tap of a shoelaced inverter/buffer chain, checks stage-by-stage
// propagation, and logs per-sample toggle masks with cycle stamps.
module interleave_chain_monitor
    import interleave_mon_pkg::*;
#(
    parameter int unsigned          N_STAGES         = 5,
    parameter logic [N_STAGES-1:0]  INV_MASK         = '1,
    parameter int unsigned          SYNC_STAGES      = 2,
    parameter int unsigned          MAX_LAT          = 8,
    parameter bit                   ALLOW_SAME_CYCLE = 1'b1,
    parameter int unsigned          LOG_DEPTH        = 8,
    parameter int unsigned          TS_W             = 16,
    localparam int unsigned         SW               = $clog2(N_STAGES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_STAGES:0]   taps,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [N_STAGES:0]   evt_mask,
    output logic [TS_W-1:0]     evt_time,
    output logic                settled,
    output logic                err,
    output logic [SW-1:0]       err_stage,
    output logic [1:0]          err_code,
    output logic                overflow
);

    localparam int unsigned AGE_W     = $clog2(MAX_LAT + 1);
    localparam logic [1:0]  FILL_DONE = 2'(SYNC_STAGES);

    logic [N_STAGES:0] s;
    logic [N_STAGES:0] p;
    logic [N_STAGES:0] tog;
    logic [N_STAGES:0] mis;
    logic [N_STAGES:1] mis_p;
    logic [N_STAGES:0] spur;
    logic [N_STAGES:0] tmo;
    logic [AGE_W-1:0]  age [1:N_STAGES];
    logic [1:0]        fill;
    logic              s_real;
    logic              first_valid;
    logic [TS_W-1:0]   ts;
    logic              evt_push;
    logic              fifo_full;
    logic              drop;
    logic              hit;
    logic [SW-1:0]     hit_stage;
    logic [1:0]        hit_code;

    if (SYNC_STAGES == 2) begin : g_sync
        logic [N_STAGES:0] sync1;
        logic [N_STAGES:0] sync2;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync1 <= '0;
                sync2 <= '0;
            end else begin
                sync1 <= taps;
                sync2 <= sync1;
            end
        end
        assign s = sync2;
    end else begin : g_nosync
        assign s = taps;
    end

    // s only carries a real tap value once the synchroniser has refilled after reset.
    assign s_real = (fill == FILL_DONE);

    always_comb begin
        tog = s ^ p;
        mis = '0;
        for (int i = 1; i <= int'(N_STAGES); i++) begin
            mis[i] = s[i] ^ s[i-1] ^ INV_MASK[i-1];
        end
    end

    always_comb begin
        spur = '0;
        tmo  = '0;
        for (int i = 1; i <= int'(N_STAGES); i++) begin
            spur[i] = first_valid && tog[i] && !mis_p[i] && !(ALLOW_SAME_CYCLE && tog[i-1]);
            tmo[i]  = first_valid && (age[i] == AGE_W'(MAX_LAT));
        end
    end

    assign evt_push = first_valid && (tog != '0);
    assign drop     = evt_push && fifo_full && !evt_ready;

    // Lowest stage wins; spurious overrides timeout at the same stage; overflow is stage 0.
    always_comb begin
        hit       = 1'b0;
        hit_stage = '0;
        hit_code  = ERR_NONE;
        for (int i = int'(N_STAGES); i >= 1; i--) begin
            if (tmo[i]) begin
                hit       = 1'b1;
                hit_stage = SW'(i);
                hit_code  = ERR_TIMEOUT;
            end
            if (spur[i]) begin
                hit       = 1'b1;
                hit_stage = SW'(i);
                hit_code  = ERR_SPUR;
            end
        end
        if (drop) begin
            hit       = 1'b1;
            hit_stage = '0;
            hit_code  = ERR_OVF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill        <= '0;
            first_valid <= 1'b0;
            p           <= '0;
            mis_p       <= '0;
            ts          <= '0;
            settled     <= 1'b0;
            err         <= 1'b0;
            err_stage   <= '0;
            err_code    <= ERR_NONE;
            overflow    <= 1'b0;
        end else begin
            ts      <= ts + TS_W'(1);
            settled <= first_valid && (mis == '0);
            if (!s_real) begin
                fill <= fill + 2'd1;
            end else begin
                p           <= s;
                mis_p       <= mis[N_STAGES:1];
                first_valid <= 1'b1;
            end
            if (drop) overflow <= 1'b1;
            if (hit && !err) begin
                err       <= 1'b1;
                err_stage <= hit_stage;
                err_code  <= hit_code;
            end
        end
    end

    // Per-stage unsettled age, saturating at the timeout threshold.
    always_ff @(posedge clk) begin
        for (int i = 1; i <= int'(N_STAGES); i++) begin
            if (!rst_n || !s_real || !mis[i]) begin
                age[i] <= '0;
            end else if (age[i] != AGE_W'(MAX_LAT)) begin
                age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

    event_fifo #(
        .WIDTH (N_STAGES + 1 + TS_W),
        .DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (evt_push),
        .wdata   ({tog, ts}),
        .pop     (evt_ready),
        .rdata_c ({evt_mask, evt_time}),
        .valid_c (evt_valid),
        .full_c  (fifo_full)
    );

endmodule

// File: doc/interleave_chain_monitor.md
Name: interleave_chain_monitor

Overview:
Parametrised, clocked monitor for an N-stage shoelaced chain of inverters or buffers split between the HDL side and prsim. Samples every chain tap once per clock and checks that each transition travels stage by stage. Flags spurious toggles and stalled stages, and logs per-cycle toggle masks with timestamps into a FIFO with a valid/ready interface. Sits in the VPI co-simulation benches beside clk_gen; it generalises fixed-length inverter chains to any length and any inversion pattern.

Parameters:
N_STAGES, 5, number of chain stages; taps are indexed 0..N_STAGES, where tap 0 is the chain input.
INV_MASK, all ones (N_STAGES bits), bit i-1 set means stage i inverts; clear means stage i buffers.
SYNC_STAGES, 2, input synchroniser depth: 0 or 2.
MAX_LAT, 8, maximum number of cycles a stage may stay unsettled before a timeout error.
ALLOW_SAME_CYCLE, 1, when 1, stage i may toggle in the same sample as stage i-1.
LOG_DEPTH, 8, depth of the event FIFO; must be a power of 2.
TS_W, 16, timestamp width.

Ports:
clk  in  1  sampling clock
rst_n  in  1  synchronous, active-low reset
taps  in  N_STAGES+1  asynchronous chain taps
evt_valid  out  1  event FIFO not empty
evt_ready  in  1  consumer accepts the head entry
evt_mask  out  N_STAGES+1  taps that toggled in the logged sample
evt_time  out  TS_W  cycle stamp of that sample
settled  out  1  every stage is consistent with its input
err  out  1  sticky error flag
err_stage  out  clog2(N_STAGES+1)  stage of the first error
err_code  out  2  01 = spurious, 10 = timeout, 11 = log overflow
overflow  out  1  sticky; an event was dropped because the FIFO was full

Behaviour:
- Reset: synchronous, active-low, clk only. All outputs are 0 during reset and in the first cycle after it. Sync flops, previous-sample register, age counters, timestamp and FIFO pointers are all cleared.
- Sampling: s is taps after SYNC_STAGES flops. An internal first_valid bit is cleared by reset. The first sample after reset only loads the previous-sample register p: no events and no errors are produced from it.
- Per-cycle derived signals:
  - tog = s ^ p.
  - mis[i] = s[i] ^ s[i-1] ^ INV_MASK[i-1], for i = 1..N_STAGES. Bit 0 is never mismatched.
  - mis_p is mis registered one cycle.
- Spurious toggle: for i >= 1, tog[i] is set while mis_p[i] is 0, and the same-cycle exemption does not apply. The exemption applies only when tog[i-1] is set and ALLOW_SAME_CYCLE is 1. A toggle on tap 0 is never spurious.
- Timeout: each stage has an age counter. It increments while mis[i] is set and clears when mis[i] is clear. A timeout is reported when the age reaches MAX_LAT.
- Error capture: only the first error is captured and then held until reset. If several errors occur in one cycle, the lowest stage index wins; spurious beats timeout at the same index. Overflow reports err_stage = 0.
- Settled: settled = first_valid AND no mis bit set. It is registered, so it has 1-cycle latency.
- Timestamp: increments every cycle after reset and wraps modulo 2^TS_W.
- Event FIFO:
  - A cycle with first_valid set and tog nonzero pushes the pair {tog, ts}.
  - Pop happens on evt_valid AND evt_ready. The head entry is presented combinationally from storage, with no read latency.
  - Push and pop in the same cycle are both allowed when the FIFO is full.
  - A push into a full FIFO with no pop drops the entry and sets overflow; it is also an error (code 11) if no earlier error was captured.
  - Pointers are clog2(LOG_DEPTH)+1 bits wide, with wrap-around by MSB compare.
- Reset in the middle of operation discards FIFO contents and errors; the sample after reset becomes the new reference.

Decomposition:
- Package interleave_mon_pkg holds:
  - the err_code localparams ERR_NONE, ERR_SPUR, ERR_TIMEOUT, ERR_OVF;
  - the event-record struct {mask, time}.
- One natural sub-module, event_fifo: a parametrised synchronous FIFO of width N_STAGES+1+TS_W and depth LOG_DEPTH, using the same clk and rst_n.

Test Plan:
- Clean ripple: N=5, all inverting, taps start at 010101. Toggle tap 0, then one tap per cycle. Expect 6 FIFO entries with masks 000001, 000010, … 100000 and consecutive timestamps, err = 0, settled back to 1.
- Same-cycle pair: toggle taps 0 and 1 together. Expect one entry with mask 000011 and no error; with ALLOW_SAME_CYCLE=0, expect err_code = 01 and err_stage = 1.
- Spurious: with all stages settled, toggle only tap 3. Expect err = 1, err_code = 01, err_stage = 3, and the entry mask 001000 still logged.
- Stall: toggle tap 0 and hold tap 1 fixed. Exactly MAX_LAT = 8 cycles after tap 0's toggle is first seen by the monitor, expect err_code = 10 and err_stage = 1, with settled = 0 throughout.
- Overflow: hold evt_ready = 0 and generate 9 toggle cycles with LOG_DEPTH = 8. Expect overflow = 1, 8 entries retained, and the ninth dropped. Then assert evt_ready = 1 and expect 8 pops in order.
- Mid-run reset: drive rst_n low for 1 cycle while 3 entries are queued and err is set. Expect evt_valid, err and overflow all 0, the timestamp restarting from 0, and no event on the first post-reset sample.
